// File: rtl/decryption_cfg_arbiter.sv
// Round-robin arbiter sharing the decryption register-file bus between NUM_REQ config masters.
// Optional WAIT timeout enabled by defining CFG_ARB_TIMEOUT_EN.
module decryption_cfg_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned REG_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*REG_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [REG_WIDTH-1:0]            rsp_rdata,
  output logic                            rsp_error,
  output logic [ADDR_WIDTH-1:0]           reg_addr,
  output logic                            reg_read,
  output logic                            reg_write,
  output logic [REG_WIDTH-1:0]            reg_wdata,
  input  logic [REG_WIDTH-1:0]            reg_rdata,
  input  logic                            reg_done,
  input  logic                            reg_error
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("decryption_cfg_arbiter: unsupported parameter set");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                 state_q, state_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [PTR_W-1:0]       grant_q, grant_d;
  logic                   write_q, write_d;
  logic [PTR_W-1:0]       arb_grant, cand;
  logic                   arb_found;

  logic [NUM_REQ-1:0]     req_ready_d, rsp_valid_d;
  logic [REG_WIDTH-1:0]   rsp_rdata_d, reg_wdata_d;
  logic                   rsp_error_d, reg_read_d, reg_write_d;
  logic [ADDR_WIDTH-1:0]  reg_addr_d;

`ifdef CFG_ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0]       tmo_q, tmo_d;
`endif

  // First pending master searching upward from ptr+1 with wrap
  always_comb begin
    arb_found = 1'b0;
    arb_grant = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = PTR_W'((32'(ptr_q) + i) % NUM_REQ);
      if (!arb_found && req_valid[cand]) begin
        arb_found = 1'b1;
        arb_grant = cand;
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    write_d     = write_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    reg_read_d  = 1'b0;
    reg_write_d = 1'b0;
    reg_addr_d  = reg_addr;
    reg_wdata_d = reg_wdata;
    rsp_rdata_d = rsp_rdata;
    rsp_error_d = rsp_error;
`ifdef CFG_ARB_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (arb_found) begin
          state_d     = ISSUE;
          ptr_d       = arb_grant;
          grant_d     = arb_grant;
          write_d     = req_write[arb_grant];
          reg_addr_d  = req_addr[32'(arb_grant)*ADDR_WIDTH +: ADDR_WIDTH];
          reg_wdata_d = req_wdata[32'(arb_grant)*REG_WIDTH +: REG_WIDTH];
          req_ready_d = NUM_REQ'(1) << arb_grant;
          reg_write_d = req_write[arb_grant];
          reg_read_d  = !req_write[arb_grant];
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef CFG_ARB_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      WAIT: begin
        if (reg_done) begin
          state_d     = IDLE;
          rsp_valid_d = NUM_REQ'(1) << grant_q;
          rsp_rdata_d = write_q ? '0 : reg_rdata;
          rsp_error_d = reg_error;
        end
`ifdef CFG_ARB_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d     = IDLE;
          rsp_valid_d = NUM_REQ'(1) << grant_q;
          rsp_rdata_d = '0;
          rsp_error_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= PTR_RST;
      grant_q   <= '0;
      write_q   <= 1'b0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
      reg_addr  <= '0;
      reg_read  <= 1'b0;
      reg_write <= 1'b0;
      reg_wdata <= '0;
`ifdef CFG_ARB_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      write_q   <= write_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_error <= rsp_error_d;
      reg_addr  <= reg_addr_d;
      reg_read  <= reg_read_d;
      reg_write <= reg_write_d;
      reg_wdata <= reg_wdata_d;
`ifdef CFG_ARB_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

endmodule

// File: tb/tb_decryption_cfg_arbiter.sv
// Scoreboard bench for decryption_cfg_arbiter with a 1-cycle register-file stub.
module tb_decryption_cfg_arbiter;

  localparam int NREQ = 2;
  localparam int TMO  = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_write, req_ready, rsp_valid;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic [15:0] rsp_rdata, reg_wdata, reg_rdata;
  logic        rsp_error, reg_read, reg_write, reg_done, reg_error;
  logic [7:0]  reg_addr;

  decryption_cfg_arbiter #(.NUM_REQ(NREQ), .ADDR_WIDTH(8), .REG_WIDTH(16), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .reg_addr(reg_addr), .reg_read(reg_read), .reg_write(reg_write), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .reg_done(reg_done), .reg_error(reg_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register-file stub: addresses >= 8'h20 are invalid; stall suppresses done
  logic [15:0] rf_mem [32];
  logic        stall = 1'b0, spur = 1'b0, rf_done, rf_err;
  logic [15:0] rf_rdata;
  always @(posedge clk) begin
    rf_done  <= 1'b0;
    rf_err   <= 1'b0;
    rf_rdata <= '0;
    if (rst_n && !stall && (reg_read || reg_write)) begin
      rf_done <= 1'b1;
      if (reg_addr >= 8'h20) rf_err <= 1'b1;
      else if (reg_read) rf_rdata <= rf_mem[reg_addr[4:0]];
      else rf_mem[reg_addr[4:0]] <= reg_wdata;
    end
  end
  assign reg_done  = rf_done | spur;
  assign reg_error = rf_err;
  assign reg_rdata = rf_rdata;

  typedef struct {int m; logic [15:0] rd; logic err;} rsp_t;
  rsp_t        exp_rsp_q[$];
  int          exp_grant_q[$];
  logic [15:0] model_mem [32];
  int          tb_ptr = 1;
  int          checks = 0, errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: pops expected grants/responses as the DUT produces them
  always @(negedge clk) begin : mon
    rsp_t       e;
    int         g;
    logic [1:0] oh;
    if (rst_n === 1'b1) begin
      if (req_ready != 0) begin
        if (exp_grant_q.size() == 0) check_eq("ready_unexpected", 32'(req_ready), 0);
        else begin
          g  = exp_grant_q.pop_front();
          oh = 2'b01 << g;
          check_eq("ready_onehot", 32'(req_ready), 32'(oh));
        end
      end
      if (rsp_valid != 0) begin
        if (exp_rsp_q.size() == 0) check_eq("rsp_unexpected", 32'(rsp_valid), 0);
        else begin
          e  = exp_rsp_q.pop_front();
          oh = 2'b01 << e.m;
          check_eq("rsp_valid", 32'(rsp_valid), 32'(oh));
          check_eq("rsp_rdata", 32'(rsp_rdata), 32'(e.rd));
          check_eq("rsp_error", 32'(rsp_error), 32'(e.err));
        end
      end
      if (req_ready != 0 && rsp_valid != 0) check_eq("ready_rsp_overlap", 1, 0);
    end
  end

  // mode 0: normal, 1: stalled (no response), 2: stalled until timeout
  task automatic run_txn(input int m, input logic w, input logic [7:0] a, input logic [15:0] d,
                         input int mode);
    logic       err;
    logic [15:0] rd;
    int         n, lat;
    err = (a >= 8'h20);
    rd  = (w || err || mode == 2) ? 16'h0 : model_mem[a[4:0]];
    if (mode == 2) err = 1'b1;
    if (w && !err && mode == 0) model_mem[a[4:0]] = d;
    exp_grant_q.push_back(m);
    tb_ptr = m;
    if (mode != 1) exp_rsp_q.push_back('{m, rd, err});
    req_write[m] = w;
    req_addr[m*8 +: 8] = a;
    req_wdata[m*16 +: 16] = d;
    req_valid[m] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready[m] && n < 20);
    check_eq("ready_latency", 32'(n), 1);
    check_eq("strobe", 32'({reg_read, reg_write}), 32'({~w, w}));
    check_eq("reg_addr", 32'(reg_addr), 32'(a));
    if (w) check_eq("reg_wdata", 32'(reg_wdata), 32'(d));
    req_valid[m] = 1'b0;
    if (mode != 1) begin
      lat = (mode == 2) ? TMO + 1 : 2;
      n = 0;
      do begin @(negedge clk); n++; end while (!rsp_valid[m] && n < 100);
      check_eq("rsp_latency", 32'(n), 32'(lat));
    end
  endtask

  // Both masters valid together, n/2 transactions each
  task automatic run_pair(input int n, input logic [7:0] a);
    int g, total = 0, c0 = 0, c1 = 0, last = 0, k = 0;
    for (int i = 0; i < n; i++) begin
      g = (tb_ptr + 1) % 2;
      tb_ptr = g;
      exp_grant_q.push_back(g);
      exp_rsp_q.push_back('{g, model_mem[a[4:0]], 1'b0});
    end
    req_write = 2'b00;
    req_addr  = {a, a};
    req_valid = 2'b11;
    while (total < n && k < 20 * n) begin
      @(negedge clk); k++;
      if (req_ready != 0) begin
        if (total > 0) check_eq("ready_gap", 32'(cyc - last), 3);
        last = cyc;
        total++;
        if (req_ready[0]) c0++; else c1++;
        if (c0 == n / 2) req_valid[0] = 1'b0;
        if (c1 == n / 2) req_valid[1] = 1'b0;
      end
    end
    check_eq("pair_count", 32'(total), 32'(n));
    req_valid = 2'b00;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_rsp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    check_eq("drain", 32'(exp_rsp_q.size()), 0);
  endtask

  task automatic check_quiet(input string tag, input int cycles);
    int seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (rsp_valid != 0 || reg_read || reg_write) seen++;
    end
    check_eq(tag, 32'(seen), 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_ctl"}, 32'({req_ready, rsp_valid, reg_read, reg_write, rsp_error, reg_addr}), 0);
    check_eq({tag, "_data"}, {reg_wdata, rsp_rdata}, 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf_mem[i] = 16'h0;
      model_mem[i] = 16'h0;
    end
    rf_mem[5'h14] = 16'h0002;
    model_mem[5'h14] = 16'h0002;
    rst_n = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(0, 1'b0, 8'h10, 16'h0, 0);
    run_txn(1, 1'b1, 8'h12, 16'h0005, 0);
    run_txn(1, 1'b0, 8'h12, 16'h0, 0);
    run_pair(4, 8'h14);
    drain();
    run_txn(0, 1'b0, 8'h33, 16'h0, 0);
    drain();

    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    check_quiet("spurious_done", 4);

    stall = 1'b1;
`ifdef CFG_ARB_TIMEOUT_EN
    run_txn(1, 1'b0, 8'h18, 16'h0, 2);
    drain();
    run_txn(0, 1'b0, 8'h18, 16'h0, 1);
    repeat (5) @(negedge clk);
`else
    run_txn(1, 1'b0, 8'h18, 16'h0, 1);
    check_quiet("wait_hold", 40);
`endif
    rst_n = 1'b0;
    @(negedge clk);
    check_zero_outputs("abort");
    rst_n = 1'b1;
    stall = 1'b0;
    tb_ptr = 1;
    check_quiet("abort_quiet", 3);
    run_pair(2, 8'h10);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
